// File: rtl/risc_mem_arbiter_if.sv
// risc_mem_arbiter_if
//   Bundles the two requester ports (IF fetch, LS load/store), the registered
//   memory-side controls and the status/perf outputs of risc_mem_arbiter.
//   slave  : arbiter view (drives acks, rdata, memory controls, busy, perf)
//   master : core/memory view (drives requests, addresses, store data, mem_rdata)
//   Ports carried:
//     if_req, if_addr, if_ack, if_rdata
//     ls_req, ls_we, ls_addr, ls_wdata, ls_ack, ls_rdata
//     mem_en, mem_we, mem_addr, mem_wdata, mem_rdata
//     busy, perf_if_cnt, perf_ls_cnt, perf_cfl_cnt
interface risc_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_ack;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic [31:0]       perf_if_cnt;
  logic [31:0]       perf_ls_cnt;
  logic [31:0]       perf_cfl_cnt;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_ack, if_rdata, ls_ack, ls_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, perf_if_cnt, perf_ls_cnt, perf_cfl_cnt
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_ack, if_rdata, ls_ack, ls_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, perf_if_cnt, perf_ls_cnt, perf_cfl_cnt
  );
endinterface

// File: rtl/risc_mem_arbiter.sv
// risc_mem_arbiter
//   Shares one synchronous-read memory between the instruction-fetch (IF) and
//   load/store (LS) ports. Each access runs IDLE -> ACCESS -> RESP -> IDLE:
//   memory controls are loaded on leaving IDLE, the memory samples them during
//   ACCESS, read data is captured in RESP and the winner gets a one-cycle ack
//   in the following (IDLE) cycle. Request-to-ack latency is 3 cycles.
//   LS wins conflicts unless IF has lost STARVE_LIMIT conflicts in a row.
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-high
//   bus  : risc_mem_arbiter_if.slave (requester ports, memory controls,
//          busy, perf counters)
// Configuration
//   ARB_PERF_CNT_EN : when defined, grant/conflict counters are built;
//                     otherwise perf_* outputs are tied to zero.
module risc_mem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic               clk,
  input  logic               rst,
  risc_mem_arbiter_if.slave  bus
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              store_q, store_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              ls_ack_q, ls_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic [SC_W-1:0]   starve_q, starve_d;

  // A port is masked in the cycle its own ack is high, so a requester that
  // has not yet dropped req cannot be granted a second time.
  logic if_eff, ls_eff, grant_any, grant_if;

  assign if_eff    = bus.if_req & ~if_ack_q;
  assign ls_eff    = bus.ls_req & ~ls_ack_q;
  assign grant_any = (state_q == IDLE) & (if_eff | ls_eff);
  assign grant_if  = if_eff & (~ls_eff | (starve_q == SC_W'(STARVE_LIMIT)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      store_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      store_q     <= store_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      ls_ack_q    <= ls_ack_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      starve_q    <= starve_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    store_d     = store_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    ls_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    starve_d    = starve_q;

    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          owner_d     = grant_if ? OWN_IF : OWN_LS;
          store_d     = ~grant_if & bus.ls_we;
          mem_en_d    = 1'b1;
          mem_we_d    = ~grant_if & bus.ls_we;
          mem_addr_d  = grant_if ? bus.if_addr : bus.ls_addr;
          mem_wdata_d = bus.ls_wdata;
          state_d     = ACCESS;
          if (grant_if) begin
            starve_d = '0;
          end else if (if_eff && (starve_q != SC_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + SC_W'(1);
          end
        end
      end
      ACCESS: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        state_d  = RESP;
      end
      RESP: begin
        if (owner_q == OWN_IF) begin
          if_rdata_d = bus.mem_rdata;
          if_ack_d   = 1'b1;
        end else begin
          if (!store_q) begin
            ls_rdata_d = bus.mem_rdata;
          end
          ls_ack_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.if_ack    = if_ack_q;
  assign bus.ls_ack    = ls_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state_q != IDLE);

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_q, perf_if_d;
  logic [31:0] perf_ls_q, perf_ls_d;
  logic [31:0] perf_cfl_q, perf_cfl_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_q  <= '0;
      perf_ls_q  <= '0;
      perf_cfl_q <= '0;
    end else begin
      perf_if_q  <= perf_if_d;
      perf_ls_q  <= perf_ls_d;
      perf_cfl_q <= perf_cfl_d;
    end
  end

  always_comb begin
    perf_if_d  = perf_if_q;
    perf_ls_d  = perf_ls_q;
    perf_cfl_d = perf_cfl_q;
    if (grant_any) begin
      if (grant_if) perf_if_d = perf_if_q + 32'd1;
      else          perf_ls_d = perf_ls_q + 32'd1;
    end
    if ((state_q == IDLE) && if_eff && ls_eff) begin
      perf_cfl_d = perf_cfl_q + 32'd1;
    end
  end

  assign bus.perf_if_cnt  = perf_if_q;
  assign bus.perf_ls_cnt  = perf_ls_q;
  assign bus.perf_cfl_cnt = perf_cfl_q;
`else
  assign bus.perf_if_cnt  = '0;
  assign bus.perf_ls_cnt  = '0;
  assign bus.perf_cfl_cnt = '0;
`endif

endmodule
